// File: rtl/pgm_wr.sv
// pgm_wr: packet-generator write stage; stores templates, parses start/stop, forwards traffic.
// Optional PGM_WR_STAT_EN adds template/bypass packet counters.
module pgm_wr #(
  parameter PLATFORM = "Xilinx"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] in_wr_phv,
  input  logic          in_wr_phv_wr,
  output logic          out_wr_phv_alf,
  input  logic [133:0]  in_wr_data,
  input  logic          in_wr_data_wr,
  input  logic          in_wr_valid,
  input  logic          in_wr_valid_wr,
  output logic          out_wr_alf,
  output logic [1023:0] out_wr_phv,
  output logic          out_wr_phv_wr,
  input  logic          in_wr_phv_alf,
  output logic [133:0]  out_wr_data,
  output logic          out_wr_data_wr,
  output logic          out_wr_valid,
  output logic          out_wr_valid_wr,
  input  logic          in_wr_alf,
  output logic          pgm_bypass_flag,
  output logic          pgm_sent_start_flag,
  output logic          pgm_sent_finish_flag,
  output logic          wr2ram_wr,
  output logic [6:0]    wr2ram_addr,
  output logic [143:0]  wr2ram_wdata,
  input  logic [133:0]  cin_wr_data,
  input  logic          cin_wr_data_wr,
  output logic          cout_wr_ready,
  output logic [133:0]  cout_wr_data,
  output logic          cout_wr_data_wr,
  input  logic          cin_wr_ready
`ifdef PGM_WR_STAT_EN
  ,
  output logic [31:0]   pgm_wr_tmpl_cnt,
  output logic [31:0]   pgm_wr_byp_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE_S, BYP_S, STORE_S, DISC_S
  } st_t;

  typedef enum logic [1:0] {
    C_TMPL, C_START, C_STOP, C_TRAF
  } cmd_t;

  st_t         state, state_n;
  cmd_t        cmd, cmd_dec;
  logic [31:0] dur_hold;
  logic [31:0] dur_cnt;
  logic        gen_active;
  logic        finish;
  logic        tmpl_ok;
  logic [7:0]  tmpl_len;

  logic        head, tail;
  logic [7:0]  opc;
  logic [6:0]  wa_n;
  logic        fwd, fwd_phv;
  logic        ram_we, ram_first;
  logic        tmpl_clr, tmpl_done;
  logic        cmd_start, cmd_stop;
  logic        byp_end, lat_hdr;
  logic        start_ok, expire;

  if (PLATFORM == "") begin : g_no_platform
  end

  assign out_wr_phv_alf  = in_wr_phv_alf;
  assign out_wr_alf      = in_wr_alf;
  assign cout_wr_ready   = cin_wr_ready;
  assign cout_wr_data    = cin_wr_data;
  assign cout_wr_data_wr = cin_wr_data_wr;

  assign pgm_bypass_flag      = ~gen_active;
  assign pgm_sent_start_flag  = gen_active;
  assign pgm_sent_finish_flag = finish;

  assign opc  = in_wr_phv[1023:1016];
  assign head = in_wr_data_wr & in_wr_phv_wr
              & (in_wr_data[133:132] == 2'b01);
  assign tail = in_wr_data_wr
              & (in_wr_data[133:132] == 2'b10);
  assign wa_n = wr2ram_addr + 7'd1;

  always_comb begin
    cmd_dec = C_TRAF;
    unique case (1'b1)
      (opc == 8'h5A): cmd_dec = C_TMPL;
      (opc == 8'hA5): cmd_dec = C_START;
      (opc == 8'hA6): cmd_dec = C_STOP;
      default:        cmd_dec = C_TRAF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE_S;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fwd       = 1'b0;
    fwd_phv   = 1'b0;
    ram_we    = 1'b0;
    ram_first = 1'b0;
    tmpl_clr  = 1'b0;
    tmpl_done = 1'b0;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    byp_end   = 1'b0;
    lat_hdr   = 1'b0;
    case (state)
      IDLE_S: begin
        if (head) begin
          lat_hdr = 1'b1;
          unique case (1'b1)
            (cmd_dec == C_TMPL): begin
              if (gen_active) begin
                state_n = DISC_S;
              end else begin
                ram_we    = 1'b1;
                ram_first = 1'b1;
                tmpl_clr  = 1'b1;
                state_n   = STORE_S;
              end
            end
            (cmd_dec == C_START),
            (cmd_dec == C_STOP): state_n = DISC_S;
            default: begin
              fwd     = 1'b1;
              fwd_phv = 1'b1;
              state_n = BYP_S;
            end
          endcase
        end
      end
      BYP_S: begin
        fwd = 1'b1;
        if (tail) begin
          byp_end = 1'b1;
          state_n = IDLE_S;
        end
      end
      STORE_S: begin
        if (in_wr_data_wr) begin
          // Address 127 already holds a flit: drop the rest of the packet.
          if (wr2ram_addr == 7'd127) begin
            state_n = tail ? IDLE_S : DISC_S;
          end else begin
            ram_we = 1'b1;
            if (tail) begin
              tmpl_done = in_wr_valid & in_wr_valid_wr;
              state_n   = IDLE_S;
            end
          end
        end
      end
      DISC_S: begin
        if (tail) begin
          cmd_start = (cmd == C_START);
          cmd_stop  = (cmd == C_STOP);
          state_n   = IDLE_S;
        end
      end
      default: state_n = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= C_TRAF;
      dur_hold <= '0;
    end else if (lat_hdr) begin
      cmd      <= cmd_dec;
      dur_hold <= in_wr_phv[1015:984];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_data     <= '0;
      out_wr_data_wr  <= 1'b0;
      out_wr_phv      <= '0;
      out_wr_phv_wr   <= 1'b0;
      out_wr_valid    <= 1'b0;
      out_wr_valid_wr <= 1'b0;
    end else begin
      out_wr_data_wr  <= fwd & in_wr_data_wr;
      out_wr_phv_wr   <= fwd_phv;
      out_wr_valid_wr <= fwd & in_wr_valid_wr;
      if (fwd & in_wr_data_wr) out_wr_data <= in_wr_data;
      if (fwd_phv) out_wr_phv <= in_wr_phv;
      if (fwd & in_wr_valid_wr) out_wr_valid <= in_wr_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr2ram_wr    <= 1'b0;
      wr2ram_addr  <= '0;
      wr2ram_wdata <= '0;
    end else begin
      wr2ram_wr <= ram_we;
      if (ram_we) begin
        wr2ram_addr  <= ram_first ? 7'd0 : wa_n;
        wr2ram_wdata <= {10'b0, in_wr_data};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmpl_ok  <= 1'b0;
      tmpl_len <= '0;
    end else if (tmpl_clr) begin
      tmpl_ok  <= 1'b0;
    end else if (tmpl_done) begin
      tmpl_ok  <= 1'b1;
      tmpl_len <= {1'b0, wa_n} + 8'd1;
    end
  end

  assign start_ok = cmd_start & tmpl_ok
                  & (dur_hold != 32'd0)
                  & (tmpl_len != 8'd0);
  assign expire   = gen_active & (dur_cnt == 32'd1);

  // An accepted start outranks a same-cycle expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_active <= 1'b0;
      finish     <= 1'b0;
      dur_cnt    <= '0;
    end else if (start_ok) begin
      gen_active <= 1'b1;
      finish     <= 1'b0;
      dur_cnt    <= dur_hold;
    end else begin
      if (gen_active) dur_cnt <= dur_cnt - 32'd1;
      if (cmd_stop | expire) begin
        gen_active <= 1'b0;
        finish     <= 1'b1;
      end
    end
  end

`ifdef PGM_WR_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pgm_wr_tmpl_cnt <= '0;
      pgm_wr_byp_cnt  <= '0;
    end else begin
      if (tmpl_done) pgm_wr_tmpl_cnt <= pgm_wr_tmpl_cnt + 32'd1;
      if (byp_end)   pgm_wr_byp_cnt  <= pgm_wr_byp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pgm_wr.sv
// tb_pgm_wr: scoreboard bench for pgm_wr.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_pgm_wr;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] in_wr_phv;
  logic          in_wr_phv_wr;
  logic          out_wr_phv_alf;
  logic [133:0]  in_wr_data;
  logic          in_wr_data_wr;
  logic          in_wr_valid;
  logic          in_wr_valid_wr;
  logic          out_wr_alf;
  logic [1023:0] out_wr_phv;
  logic          out_wr_phv_wr;
  logic          in_wr_phv_alf;
  logic [133:0]  out_wr_data;
  logic          out_wr_data_wr;
  logic          out_wr_valid;
  logic          out_wr_valid_wr;
  logic          in_wr_alf;
  logic          pgm_bypass_flag;
  logic          pgm_sent_start_flag;
  logic          pgm_sent_finish_flag;
  logic          wr2ram_wr;
  logic [6:0]    wr2ram_addr;
  logic [143:0]  wr2ram_wdata;
  logic [133:0]  cin_wr_data;
  logic          cin_wr_data_wr;
  logic          cout_wr_ready;
  logic [133:0]  cout_wr_data;
  logic          cout_wr_data_wr;
  logic          cin_wr_ready;

  int total = 0;
  int bad   = 0;

  logic [133:0]  q_out[$];
  logic [1023:0] q_phv[$];
  logic          q_vld[$];
  logic [150:0]  q_ram[$];

  always #5 clk = ~clk;

  pgm_wr #(.PLATFORM("Xilinx")) dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr),
    .out_wr_phv_alf(out_wr_phv_alf),
    .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
    .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr),
    .out_wr_alf(out_wr_alf),
    .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr),
    .in_wr_phv_alf(in_wr_phv_alf),
    .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
    .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr),
    .in_wr_alf(in_wr_alf),
    .pgm_bypass_flag(pgm_bypass_flag),
    .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr),
    .wr2ram_wdata(wr2ram_wdata),
    .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr),
    .cout_wr_ready(cout_wr_ready), .cout_wr_data(cout_wr_data),
    .cout_wr_data_wr(cout_wr_data_wr), .cin_wr_ready(cin_wr_ready)
  );

  function automatic void chk(string nm, logic [1023:0] act,
                              logic [1023:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic void extra(string nm);
    total++;
    bad++;
    $display("FAIL %s unexpected output, queue empty", nm);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_wr_data_wr) begin
        if (q_out.size() == 0) extra("out_data");
        else chk("out_data", 1024'(out_wr_data), 1024'(q_out.pop_front()));
      end
      if (out_wr_phv_wr) begin
        if (q_phv.size() == 0) extra("out_phv");
        else chk("out_phv", out_wr_phv, q_phv.pop_front());
      end
      if (out_wr_valid_wr) begin
        if (q_vld.size() == 0) extra("out_valid");
        else chk("out_valid", 1024'(out_wr_valid), 1024'(q_vld.pop_front()));
      end
      if (wr2ram_wr) begin
        if (q_ram.size() == 0) extra("ram_wr");
        else chk("ram_wr", 1024'({wr2ram_addr, wr2ram_wdata}),
                 1024'(q_ram.pop_front()));
      end
    end
  end

  function automatic logic [133:0] mkflit(int i, int n, int base);
    logic [1:0] t;
    t = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    return {t, 132'(base + i)};
  endfunction

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_wr_data_wr  = 1'b0;
      in_wr_phv_wr   = 1'b0;
      in_wr_valid_wr = 1'b0;
      in_wr_valid    = 1'b0;
    end
  endtask

  // fwd: expect the packet on out_wr_*; nram: expected RAM writes from flit 0.
  task automatic pkt(input logic [7:0] opc, input logic [31:0] dur,
                     input int n, input bit vld, input int base,
                     input bit fwd, input int nram);
    logic [1023:0] phv;
    logic [133:0]  f;
    phv = {opc, dur, 984'(base)};
    if (fwd) begin
      q_phv.push_back(phv);
      q_vld.push_back(vld);
    end
    for (int i = 0; i < n; i++) begin
      f = mkflit(i, n, base);
      if (fwd) q_out.push_back(f);
      if (i < nram) q_ram.push_back({7'(i), 10'b0, f});
      @(posedge clk);
      #1;
      in_wr_phv      = phv;
      in_wr_phv_wr   = (i == 0);
      in_wr_data     = f;
      in_wr_data_wr  = 1'b1;
      in_wr_valid_wr = (i == n - 1);
      in_wr_valid    = vld && (i == n - 1);
    end
    idle(1);
  endtask

  task automatic flags(string nm, bit byp, bit st, bit fin);
    chk({nm, "_bypass"}, 1024'(pgm_bypass_flag), 1024'(byp));
    chk({nm, "_start"}, 1024'(pgm_sent_start_flag), 1024'(st));
    chk({nm, "_finish"}, 1024'(pgm_sent_finish_flag), 1024'(fin));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n          = 1'b0;
    in_wr_phv      = '0;
    in_wr_phv_wr   = 1'b0;
    in_wr_data     = '0;
    in_wr_data_wr  = 1'b0;
    in_wr_valid    = 1'b0;
    in_wr_valid_wr = 1'b0;
    in_wr_phv_alf  = 1'b0;
    in_wr_alf      = 1'b1;
    cin_wr_data    = 134'h2A5A5;
    cin_wr_data_wr = 1'b1;
    cin_wr_ready   = 1'b1;
    #12;
    flags("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_out_wr", 1024'(out_wr_data_wr), 1024'(0));
    chk("reset_ram_wr", 1024'(wr2ram_wr), 1024'(0));
    chk("alf_pass", 1024'({out_wr_alf, out_wr_phv_alf}), 1024'(2'b10));
    chk("cout_pass", 1024'({cout_wr_ready, cout_wr_data_wr, cout_wr_data}),
        1024'({2'b11, 134'h2A5A5}));
    rst_n = 1'b1;
    idle(2);

    // 4-flit valid template: RAM 0..3, nothing forwarded
    pkt(8'h5A, 32'd0, 4, 1'b1, 'h100, 1'b0, 4);
    idle(2);

    // 3-flit traffic forwarded
    pkt(8'h00, 32'h1234, 3, 1'b1, 'h200, 1'b1, 0);
    idle(2);
    flags("bypass", 1'b1, 1'b0, 1'b0);

    // start, duration 10
    pkt(8'hA5, 32'd10, 2, 1'b1, 'h300, 1'b0, 0);
    c = 0;
    while (pgm_sent_start_flag && c < 50) begin
      c++;
      @(posedge clk);
      #1;
    end
    chk("start_cycles", 1024'(c), 1024'(10));
    flags("expired", 1'b1, 1'b0, 1'b1);
    idle(3);
    flags("expired_hold", 1'b1, 1'b0, 1'b1);

    // invalid template then start: ignored
    pkt(8'h5A, 32'd0, 3, 1'b0, 'h400, 1'b0, 3);
    pkt(8'hA5, 32'd5, 2, 1'b1, 'h410, 1'b0, 0);
    idle(1);
    flags("start_no_tmpl", 1'b1, 1'b0, 1'b1);

    // valid template then start with zero duration: ignored
    pkt(8'h5A, 32'd0, 3, 1'b1, 'h500, 1'b0, 3);
    pkt(8'hA5, 32'd0, 2, 1'b1, 'h510, 1'b0, 0);
    idle(1);
    flags("start_dur0", 1'b1, 1'b0, 1'b1);

    // 130-flit template: only 0..127 written, following start ignored
    pkt(8'h5A, 32'd0, 130, 1'b1, 'h1000, 1'b0, 128);
    idle(2);
    pkt(8'hA5, 32'd5, 2, 1'b1, 'h600, 1'b0, 0);
    idle(1);
    flags("start_ovf", 1'b1, 1'b0, 1'b1);

    // protection: template during generation is dropped
    pkt(8'h5A, 32'd0, 4, 1'b1, 'h700, 1'b0, 4);
    pkt(8'hA5, 32'd100, 2, 1'b1, 'h710, 1'b0, 0);
    idle(1);
    flags("gen_on", 1'b0, 1'b1, 1'b0);
    pkt(8'h5A, 32'd0, 4, 1'b1, 'h720, 1'b0, 0);
    pkt(8'h11, 32'd7, 3, 1'b0, 'h730, 1'b1, 0);
    idle(1);
    flags("gen_still", 1'b0, 1'b1, 1'b0);
    pkt(8'hA6, 32'd0, 2, 1'b1, 'h740, 1'b0, 0);
    flags("stopped", 1'b1, 1'b0, 1'b1);
    idle(2);

    // reset in the middle of a template store
    q_ram.push_back({7'd0, 10'b0, mkflit(0, 4, 'h800)});
    q_ram.push_back({7'd1, 10'b0, mkflit(1, 4, 'h800)});
    @(posedge clk);
    #1;
    in_wr_phv      = {8'h5A, 32'd0, 984'(0)};
    in_wr_phv_wr   = 1'b1;
    in_wr_data     = mkflit(0, 4, 'h800);
    in_wr_data_wr  = 1'b1;
    @(posedge clk);
    #1;
    in_wr_phv_wr   = 1'b0;
    in_wr_data     = mkflit(1, 4, 'h800);
    idle(1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    flags("mid_rst", 1'b1, 1'b0, 1'b0);
    chk("mid_rst_ram", 1024'({wr2ram_wr, wr2ram_addr}), 1024'(0));
    chk("mid_rst_out", 1024'({out_wr_data_wr, out_wr_phv_wr}), 1024'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // leftover flits without a head are ignored
    @(posedge clk);
    #1;
    in_wr_data     = mkflit(2, 4, 'h800);
    in_wr_data_wr  = 1'b1;
    @(posedge clk);
    #1;
    in_wr_data     = mkflit(3, 4, 'h800);
    in_wr_valid    = 1'b1;
    in_wr_valid_wr = 1'b1;
    idle(2);
    pkt(8'hA5, 32'd5, 2, 1'b1, 'h900, 1'b0, 0);
    idle(1);
    flags("start_after_rst", 1'b1, 1'b0, 1'b0);
    pkt(8'h00, 32'd0, 2, 1'b1, 'hA00, 1'b1, 0);
    idle(4);

    chk("q_out_empty", 1024'(q_out.size()), 1024'(0));
    chk("q_phv_empty", 1024'(q_phv.size()), 1024'(0));
    chk("q_vld_empty", 1024'(q_vld.size()), 1024'(0));
    chk("q_ram_empty", 1024'(q_ram.size()), 1024'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pgm_wr.md
# pgm_wr

Write-side stage of the packet generator, directly upstream of `pgm_rd`. It parses the packet/PHV stream from the UA path and classifies each packet as one of:
- a template, stored flit by flit into PGM_RAM;
- a start or stop command;
- ordinary traffic, forwarded unchanged.

It drives the bypass/start/finish flags that `pgm_rd` uses to choose between forwarding traffic and replaying the stored template.

## Interface
Parameters:
- PLATFORM, "Xilinx", target vendor tag; no functional effect.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- in_wr_phv  in  1024  PHV of the current packet; [1023:1016] = opcode, [1015:984] = generation duration in cycles.
- in_wr_phv_wr  in  1  PHV strobe, once per packet, coincident with the head flit.
- out_wr_phv_alf  out  1  equals in_wr_phv_alf.
- in_wr_data  in  134  flit; [133:132] 01 head, 11 middle, 10 tail.
- in_wr_data_wr  in  1  flit strobe.
- in_wr_valid  in  1  packet valid, sampled with the tail.
- in_wr_valid_wr  in  1  valid strobe.
- out_wr_alf  out  1  equals in_wr_alf.
- out_wr_phv  out  1024  registered PHV toward pgm_rd.
- out_wr_phv_wr  out  1  registered PHV strobe.
- in_wr_phv_alf  in  1  downstream PHV almost-full.
- out_wr_data  out  134  registered flit.
- out_wr_data_wr  out  1  registered flit strobe.
- out_wr_valid  out  1  registered packet valid.
- out_wr_valid_wr  out  1  registered valid strobe.
- in_wr_alf  in  1  downstream data almost-full.
- pgm_bypass_flag  out  1  1 = generator idle; traffic is forwarded.
- pgm_sent_start_flag  out  1  1 = generation active.
- pgm_sent_finish_flag  out  1  1 = duration expired; held until the next accepted start.
- wr2ram_wr  out  1  RAM write enable.
- wr2ram_addr  out  7  RAM write address.
- wr2ram_wdata  out  144  {10'b0, flit}.
- cin_wr_data  in  134  configuration flit from DMA.
- cin_wr_data_wr  in  1  configuration strobe.
- cout_wr_ready  out  1  equals cin_wr_ready.
- cout_wr_data  out  134  equals cin_wr_data.
- cout_wr_data_wr  out  1  equals cin_wr_data_wr.
- cin_wr_ready  in  1  ready from the next module.

## Operation
Opcodes, decoded on the head flit (in_wr_phv_wr=1, [133:132]=01):
- 8'h5A: template.
- 8'hA5: start.
- 8'hA6: stop.
- anything else: traffic.

Parser FSM:
- IDLE_S
  - Head with a traffic opcode: forward the flit and PHV, go to BYP_S.
  - Template head while gen_active=0: write the flit at address 0, clear tmpl_ok, go to STORE_S.
  - Template head while gen_active=1: go to DISC_S; the running template is never overwritten.
  - Start or stop head: go to DISC_S and act on the command at the tail.
- BYP_S
  - Forward every flit with its strobes.
  - On the tail, return to IDLE_S.
- STORE_S
  - Each flit is written at the incremented address.
  - On a tail with in_wr_valid=1: set tmpl_ok and tmpl_len = address+1.
  - On a tail with in_wr_valid=0: tmpl_ok stays 0.
  - Return to IDLE_S after the tail.
  - If a flit would land past address 127: stop writing, keep tmpl_ok=0, go to DISC_S.
- DISC_S
  - Consume flits up to the tail with no output.
  - On a start tail: if tmpl_ok=1 and duration≠0, load dur_cnt = duration, set gen_active, clear finish. Otherwise ignore the command.
  - On a stop tail: clear gen_active and set finish.
  - Return to IDLE_S.

Generation timer:
- While gen_active=1, dur_cnt decrements by 1 per cycle.
- On the cycle dur_cnt reaches 1: clear gen_active and set finish.
- Flag mapping: pgm_bypass_flag = ~gen_active, pgm_sent_start_flag = gen_active.

Other rules:
- Traffic arriving while gen_active=1 is still forwarded; pgm_rd decides its fate.
- A start that arrives while gen_active=1 reloads dur_cnt.
- Control and template packets never appear on the out_wr_* ports.

## Timing
- Every registered output resets to 0, except pgm_bypass_flag, which resets to 1.
- Data path latency is 1 cycle, in_wr_* to out_wr_* and in_wr_* to wr2ram_*.
- The alf and ready signals are combinational pass-throughs. Upstream honours them; this block does not buffer.
- Flags update 1 cycle after a command tail or timer expiry.
- When expiry and a stop occur in the same cycle, the result is one finish assertion.
- A start tail arriving in the same cycle as expiry wins: gen_active=1 and finish=0.
- An rst_n assertion mid-packet aborts the packet and clears tmpl_ok, so a partial template is lost. The parser resynchronises on the next head.

## Configuration
- PGM_WR_STAT_EN defined:
  - Adds two 32-bit outputs: pgm_wr_tmpl_cnt (templates stored with tmpl_ok) and pgm_wr_byp_cnt (traffic packets forwarded).
  - Both counters wrap at 2^32 and reset to 0.
- PGM_WR_STAT_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Template store: 4-flit template (5A) with valid=1. Expect wr2ram addresses 0..3 with data matching the input, tmpl_ok=1, tmpl_len=4, and no out_wr_data_wr.
- Bypass: 3-flit packet with opcode 00. Expect identical flits on out_wr_* one cycle later, PHV strobe on the head, and pgm_bypass_flag=1.
- Start/expiry: template, then start with duration 10. Expect start_flag=1 for exactly 10 cycles, then finish=1 and bypass=1 held.
- Guarded start: start with no valid template, and start with duration 0. Expect flags unchanged.
- Overflow: 130-flit template. Expect writes at 0..127 only, tmpl_ok=0, and a following start ignored.
- Protection/reset: template sent while generating produces no RAM writes. Asserting rst_n low mid-store clears all outputs and sets bypass=1.
